// File: rtl/lc3b_pkg.sv
// Shared definitions for the LC-3b memory load path.
//   state_t   : loader FSM encoding (IDLE / ACCESS / DONE)
//   SIZE_*    : data_size encoding (0 byte, 1 word)
//   RW_*      : r_w encoding (0 read, 1 write)
package lc3b_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;
    localparam logic RW_READ   = 1'b0;
    localparam logic RW_WRITE  = 1'b1;

endpackage

// File: rtl/mdr_byte_format.sv
// Combinational formatting for the MDR path.
// Ports:
//   data_size  in  1   size of a bus load into MDR (0 byte, 1 word)
//   bus_in     in  16  shared datapath bus value
//   acc_size   in  1   size of the memory access in flight
//   addr_lsb   in  1   MAR[0], selects the byte lane for byte writes
//   bus_fmt    out 16  bus value as it should land in MDR
//   we         out 2   byte-lane enables {hi,lo} for a write of acc_size
module mdr_byte_format
    import lc3b_pkg::*;
(
    input  logic        data_size,
    input  logic [15:0] bus_in,
    input  logic        acc_size,
    input  logic        addr_lsb,
    output logic [15:0] bus_fmt,
    output logic [1:0]  we
);

    // A byte load replicates the low byte into both halves so either lane
    // can be written back to memory without further shifting.
    always_comb begin
        bus_fmt = bus_in;
        if (data_size == SIZE_BYTE) begin
            bus_fmt = {bus_in[7:0], bus_in[7:0]};
        end
    end

    always_comb begin
        we = 2'b11;
        if (acc_size == SIZE_BYTE) begin
            we = addr_lsb ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mdr_mem_loader.sv
// Load side of the LC-3b memory data path: MAR/MDR capture from the bus or
// memory, the memory request/ready handshake and the R signal.
// Handshake: mem_req is held high (registered) for the whole access; the
// first rising edge that sees mem_ready=1 while in ACCESS completes it and
// mem_req drops at that same edge. mem_ready outside ACCESS has no effect.
// Ports:
//   clock, reset_n          clock (rising edge), async active-low reset
//   ld_mar, ld_mdr          register load strobes (honoured in IDLE only,
//                           except ld_mdr gating the read capture)
//   mio_en                  1: start/hold a memory access, 0: bus source
//   r_w, data_size          access type and size, latched at access start
//   bus_in                  datapath bus
//   mem_rdata, mem_ready    memory response
//   mar_out, mdr_out        MAR and MDR contents
//   mem_req, mem_we         memory request and byte write enables
//   r                       access complete (high while in DONE)
//   err                     sticky timeout / unaligned-word flag
module mdr_mem_loader
    import lc3b_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_W         = 5
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        data_size,
    input  logic [15:0] bus_in,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] mar_out,
    output logic [15:0] mdr_out,
    output logic        mem_req,
    output logic [1:0]  mem_we,
    output logic        r,
    output logic        err
);

    localparam logic [WAIT_W-1:0] LP_LAST_WAIT = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic [15:0]       r_mar;
    logic [15:0]       r_mdr;
    logic              r_mem_req;
    logic              r_err;
    logic              r_rw;
    logic              r_size;
    logic [WAIT_W-1:0] r_wait_cnt;

    logic              w_start;
    logic              w_unaligned;
    logic              w_complete;
    logic              w_timeout;
    logic [15:0]       w_bus_fmt;
    logic [1:0]        w_we;

    mdr_byte_format u_fmt (
        .data_size (data_size),
        .bus_in    (bus_in),
        .acc_size  (r_size),
        .addr_lsb  (r_mar[0]),
        .bus_fmt   (w_bus_fmt),
        .we        (w_we)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_unaligned = 1'b0;
        w_complete  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mio_en) begin
                    w_start = 1'b1;
                    // Checked against the MAR held before this edge, so a
                    // same-edge ld_mar does not affect alignment.
                    if (data_size == SIZE_WORD && r_mar[0]) begin
                        w_unaligned = 1'b1;
                        w_next      = ST_DONE;
                    end else begin
                        w_next = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    w_complete = 1'b1;
                    w_next     = ST_DONE;
                end else if (r_wait_cnt == LP_LAST_WAIT) begin
                    w_timeout = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!mio_en) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mar      <= '0;
            r_mdr      <= '0;
            r_mem_req  <= 1'b0;
            r_err      <= 1'b0;
            r_rw       <= 1'b0;
            r_size     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && ld_mar) begin
                r_mar <= bus_in;
            end
            if (r_state == ST_IDLE && ld_mdr && !mio_en) begin
                r_mdr <= w_bus_fmt;
            end
            if (w_start) begin
                r_rw       <= r_w;
                r_size     <= data_size;
                r_wait_cnt <= '0;
                if (!w_unaligned) begin
                    r_mem_req <= 1'b1;
                end
            end
            if (r_state == ST_ACCESS && !mem_ready && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + 1'b1;
            end
            if (w_complete && r_rw == RW_READ && ld_mdr) begin
                r_mdr <= mem_rdata;
            end
            if (w_complete || w_timeout) begin
                r_mem_req <= 1'b0;
            end
            if (w_unaligned || w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign mar_out = r_mar;
    assign mdr_out = r_mdr;
    assign mem_req = r_mem_req;
    // Lane enables exist only while a write request is outstanding.
    assign mem_we  = (r_mem_req && r_rw == RW_WRITE) ? w_we : 2'b00;
    assign r       = (r_state == ST_DONE);
    assign err     = r_err;

endmodule

// File: tb/tb_mdr_mem_loader.sv
module tb_mdr_mem_loader;

    logic        clock;
    logic        reset_n;
    logic        ld_mar;
    logic        ld_mdr;
    logic        mio_en;
    logic        r_w;
    logic        data_size;
    logic [15:0] bus_in;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] mar_out;
    logic [15:0] mdr_out;
    logic        mem_req;
    logic [1:0]  mem_we;
    logic        r;
    logic        err;

    logic [15:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          req_cycles;
    logic [1:0]  we_seen;
    logic [15:0] rand_word;

    mdr_mem_loader dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .ld_mar    (ld_mar),
        .ld_mdr    (ld_mdr),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .data_size (data_size),
        .bus_in    (bus_in),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .mar_out   (mar_out),
        .mdr_out   (mdr_out),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .r         (r),
        .err       (err)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        ld_mar    = 1'b0;
        ld_mdr    = 1'b0;
        mio_en    = 1'b0;
        r_w       = 1'b0;
        data_size = 1'b0;
        bus_in    = 16'h0000;
        mem_rdata = 16'h0000;
        mem_ready = 1'b0;
    endtask

    // checking
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input string tag);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, mdr_out %h", tag, mdr_out);
        end else begin
            chk(tag, mdr_out, exp_q.pop_front());
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mar"}, mar_out, 16'h0000);
        chk({tag, "_mdr"}, mdr_out, 16'h0000);
        chk({tag, "_req"}, 16'(mem_req), 16'd0);
        chk({tag, "_we"},  16'(mem_we), 16'd0);
        chk({tag, "_r"},   16'(r), 16'd0);
        chk({tag, "_err"}, 16'(err), 16'd0);
    endtask

    // drivers
    task automatic load_mar(input logic [15:0] v);
        ld_mar = 1'b1;
        bus_in = v;
        tick();
        ld_mar = 1'b0;
        chk("mar_load", mar_out, v);
    endtask

    task automatic load_mdr_bus(input logic [15:0] v, input logic size, input logic [15:0] exp);
        ld_mdr    = 1'b1;
        mio_en    = 1'b0;
        data_size = size;
        bus_in    = v;
        exp_q.push_back(exp);
        tick();
        ld_mdr = 1'b0;
        sb_check("mdr_bus_load");
    endtask

    // Simple memory model: raises mem_ready on the ready_after-th cycle of
    // mem_req (0 = never). Bounded so a stuck DUT cannot hang the run.
    task automatic run_access(input int ready_after, input logic [15:0] rdata,
                              output int cycles, output logic [1:0] we);
        cycles = 0;
        we     = 2'b00;
        for (int i = 0; i < 40; i++) begin
            if (r) break;
            if (mem_req) begin
                cycles++;
                we = mem_we;
                if (cycles == ready_after) begin
                    mem_ready = 1'b1;
                    mem_rdata = rdata;
                end
            end
            tick();
            mem_ready = 1'b0;
            mem_rdata = 16'h0000;
        end
        chk("access_done_r", 16'(r), 16'd1);
    endtask

    task automatic end_access();
        mio_en = 1'b0;
        ld_mdr = 1'b0;
        tick();
        chk("r_after_release", 16'(r), 16'd0);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        reset_n = 1'b0;
        #2;
        chk_all_zero("reset");
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        tick();

        // 1, 2: bus loads
        load_mdr_bus(16'h1234, 1'b1, 16'h1234);
        load_mdr_bus(16'hABCD, 1'b0, 16'hCDCD);
        rand_word = 16'($urandom_range(0, 16'hFFFF));
        load_mdr_bus(rand_word, 1'b0, {rand_word[7:0], rand_word[7:0]});

        // 3: read, ready on third request cycle
        load_mar(16'h3000);
        mio_en    = 1'b1;
        ld_mdr    = 1'b1;
        r_w       = 1'b0;
        data_size = 1'b1;
        exp_q.push_back(16'hBEEF);
        tick();
        chk("rd_req_up", 16'(mem_req), 16'd1);
        chk("rd_we", 16'(mem_we), 16'd0);
        chk("rd_r_low", 16'(r), 16'd0);
        run_access(3, 16'hBEEF, req_cycles, we_seen);
        chk("rd_req_cycles", 16'(req_cycles), 16'd3);
        chk("rd_req_down", 16'(mem_req), 16'd0);
        sb_check("rd_mdr");
        tick();
        chk("rd_r_held", 16'(r), 16'd1);
        // ld_mdr from bus outside IDLE must be ignored
        mio_en = 1'b0;
        ld_mdr = 1'b1;
        bus_in = 16'hFFFF;
        exp_q.push_back(16'hBEEF);
        tick();
        ld_mdr = 1'b0;
        chk("rd_r_release", 16'(r), 16'd0);
        sb_check("mdr_ignored_in_done");

        // 4: byte write to odd address
        load_mar(16'h3001);
        load_mdr_bus(16'h00AA, 1'b1, 16'h00AA);
        mio_en    = 1'b1;
        r_w       = 1'b1;
        data_size = 1'b0;
        exp_q.push_back(16'h00AA);
        tick();
        chk("wr_we_start", 16'(mem_we), 16'b10);
        run_access(2, 16'h5A5A, req_cycles, we_seen);
        chk("wr_we_seen", 16'(we_seen), 16'b10);
        chk("wr_req_cycles", 16'(req_cycles), 16'd2);
        chk("wr_we_after", 16'(mem_we), 16'd0);
        chk("wr_err", 16'(err), 16'd0);
        sb_check("wr_mdr_kept");
        end_access();

        // 5: unaligned word read
        mio_en    = 1'b1;
        r_w       = 1'b0;
        data_size = 1'b1;
        ld_mdr    = 1'b1;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("ua_r", 16'(r), 16'd1);
        chk("ua_err", 16'(err), 16'd1);
        chk("ua_req", 16'(mem_req), 16'd0);
        chk("ua_mdr", mdr_out, 16'h00AA);
        end_access();
        chk("ua_err_sticky", 16'(err), 16'd1);

        // reset clears err
        reset_n = 1'b0;
        #2;
        chk_all_zero("reset2");
        tick();
        reset_n = 1'b1;
        tick();

        // ld_mar with start: alignment uses old MAR
        load_mar(16'h3000);
        ld_mar    = 1'b1;
        bus_in    = 16'h3001;
        mio_en    = 1'b1;
        r_w       = 1'b0;
        data_size = 1'b1;
        ld_mdr    = 1'b1;
        tick();
        ld_mar = 1'b0;
        chk("sim_mar", mar_out, 16'h3001);
        chk("sim_req", 16'(mem_req), 16'd1);
        chk("sim_err", 16'(err), 16'd0);
        exp_q.push_back(16'h1111);
        run_access(1, 16'h1111, req_cycles, we_seen);
        chk("sim_req_cycles", 16'(req_cycles), 16'd1);
        sb_check("sim_mdr");
        end_access();

        // 6: timeout, MDR unchanged
        load_mar(16'h3000);
        load_mdr_bus(16'h5555, 1'b1, 16'h5555);
        mio_en    = 1'b1;
        r_w       = 1'b0;
        data_size = 1'b1;
        ld_mdr    = 1'b1;
        exp_q.push_back(16'h5555);
        tick();
        run_access(0, 16'h0000, req_cycles, we_seen);
        chk("to_req_cycles", 16'(req_cycles), 16'd16);
        chk("to_err", 16'(err), 16'd1);
        chk("to_req", 16'(mem_req), 16'd0);
        sb_check("to_mdr");
        end_access();

        // reset in the middle of an access
        mio_en = 1'b1;
        tick();
        tick();
        chk("mid_req", 16'(mem_req), 16'd1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        idle_inputs();
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_reset_req", 16'(mem_req), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
